// File: rtl/delta_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delta_arbiter_pkg
// Purpose  : Shared channel sizing and saturating-add helpers for the
//            output filter's delta arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package delta_arbiter_pkg;

    // Must track the output filter's endpoint map.
    localparam int c_n_chan = 8;
    localparam int c_w_chan = 5;

    function automatic logic signed [32:0] sat_sum(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return {a[31], a} + {b[31], b};
    endfunction

    function automatic logic signed [32:0] sat_hi(input int w);
        return (33'sd1 <<< (w - 1)) - 33'sd1;
    endfunction

    // Width-w saturating add; operands are w-bit values sign-extended to 32 bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = sat_sum(a, b);
        hi  = sat_hi(w);
        lo  = -hi - 33'sd1;
        if (sum > hi)
            return hi[31:0];
        else if (sum < lo)
            return lo[31:0];
        else
            return sum[31:0];
    endfunction

    function automatic logic sat_ovf(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        sum = sat_sum(a, b);
        hi  = sat_hi(w);
        return (sum > hi) || (sum < (-hi - 33'sd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/delta_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first eligible channel above
//            the last grant, wrapping modulo N_CHAN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_CHAN = 8,
    parameter int W_CHAN = 5
) (
    input  logic [N_CHAN-1:0] eligible,
    input  logic [W_CHAN-1:0] last,
    input  logic              enable,
    output logic              grant_valid,
    output logic [W_CHAN-1:0] grant_idx
);

    logic [2*N_CHAN-1:0] w_dbl;
    logic [N_CHAN-1:0]   w_rot;
    logic [W_CHAN:0]     w_start;

    // Rotating a doubled copy puts channel last+1 at bit 0.
    assign w_start = {1'b0, last} + (W_CHAN+1)'(1);
    assign w_dbl   = {eligible, eligible};
    assign w_rot   = N_CHAN'(w_dbl >> w_start);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N_CHAN - 1; k >= 0; k--) begin
            if (enable && w_rot[k]) begin
                grant_valid = 1'b1;
                grant_idx   = W_CHAN'((int'(w_start) + k) % N_CHAN);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/delta_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : delta_arbiter
// Purpose  : Coalescing per-channel delta buffers, round-robin granted onto
//            the output filter's single delta port, with periodic idle slots.
// Revision : 1.0 - initial release
// ============================================================================
module delta_arbiter
    import delta_arbiter_pkg::*;
#(
    parameter int N_CHAN      = c_n_chan,
    parameter int W_CHAN      = c_w_chan,
    parameter int W_DELTA     = 18,
    parameter int IDLE_PERIOD = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [N_CHAN-1:0]           req_dv_in,
    input  logic [N_CHAN*W_DELTA-1:0]   req_delta_in,
    input  logic [N_CHAN-1:0]           clr_in,
    output logic [N_CHAN-1:0]           pend_out,
    output logic [N_CHAN-1:0]           ovf_out,
    output logic                        dv_out,
    output logic [W_CHAN-1:0]           chan_out,
    output logic signed [W_DELTA-1:0]   delta_out
);

    localparam int c_w_idle = (IDLE_PERIOD > 1) ? $clog2(IDLE_PERIOD) : 1;

    logic [N_CHAN-1:0]          r_pend;
    logic [N_CHAN-1:0]          r_ovf;
    logic signed [W_DELTA-1:0]  r_buf [N_CHAN];
    logic [W_CHAN-1:0]          r_last;
    logic [c_w_idle-1:0]        r_idle_cnt;
    logic                       r_dv;
    logic [W_CHAN-1:0]          r_chan;
    logic signed [W_DELTA-1:0]  r_delta;

    logic                       w_idle_slot;
    logic [N_CHAN-1:0]          w_eligible;
    logic [N_CHAN-1:0]          w_granted;
    logic                       w_grant_valid;
    logic [W_CHAN-1:0]          w_grant_idx;
    logic signed [W_DELTA-1:0]  w_req_delta [N_CHAN];
    logic signed [W_DELTA-1:0]  w_sum [N_CHAN];
    logic [N_CHAN-1:0]          w_sum_ovf;
    logic signed [W_DELTA-1:0]  w_sel_delta;

    generate
        for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
            assign w_req_delta[i] = req_delta_in[i*W_DELTA +: W_DELTA];
            assign w_granted[i]   = w_grant_valid && (w_grant_idx == W_CHAN'(i));
            assign w_sum[i]       = W_DELTA'(sat_add(32'(r_buf[i]), 32'(w_req_delta[i]), W_DELTA));
            assign w_sum_ovf[i]   = sat_ovf(32'(r_buf[i]), 32'(w_req_delta[i]), W_DELTA);
        end
    endgenerate

    assign w_idle_slot = (IDLE_PERIOD != 0) && (r_idle_cnt == c_w_idle'(IDLE_PERIOD - 1));
    assign w_eligible  = r_pend & ~clr_in;

    rr_arbiter #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN)
    ) u_rr_arbiter (
        .eligible    (w_eligible),
        .last        (r_last),
        .enable      (~w_idle_slot),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_sel_delta = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (w_granted[i])
                w_sel_delta = r_buf[i];
        end
    end

    // A granted channel ships its old value; a same-cycle delta starts a new entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pend <= '0;
            r_ovf  <= '0;
            for (int i = 0; i < N_CHAN; i++)
                r_buf[i] <= '0;
        end else begin
            r_ovf <= '0;
            for (int i = 0; i < N_CHAN; i++) begin
                if (clr_in[i]) begin
                    r_pend[i] <= 1'b0;
                    r_buf[i]  <= '0;
                end else if (w_granted[i]) begin
                    if (req_dv_in[i])
                        r_buf[i] <= w_req_delta[i];
                    else
                        r_pend[i] <= 1'b0;
                end else if (req_dv_in[i]) begin
                    if (r_pend[i]) begin
                        r_buf[i] <= w_sum[i];
                        r_ovf[i] <= w_sum_ovf[i];
                    end else begin
                        r_buf[i]  <= w_req_delta[i];
                        r_pend[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_idle_cnt <= '0;
        else if (IDLE_PERIOD == 0 || w_idle_slot)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + c_w_idle'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_last  <= W_CHAN'(N_CHAN - 1);
            r_dv    <= 1'b0;
            r_chan  <= '0;
            r_delta <= '0;
        end else begin
            r_dv <= w_grant_valid;
            if (w_grant_valid) begin
                r_last  <= w_grant_idx;
                r_chan  <= w_grant_idx;
                r_delta <= w_sel_delta;
            end
        end
    end

    assign pend_out  = r_pend;
    assign ovf_out   = r_ovf;
    assign dv_out    = r_dv;
    assign chan_out  = r_chan;
    assign delta_out = r_delta;

endmodule
`default_nettype wire
